// File: rtl/ledger_access_sequencer.sv
// Multi-cycle ledger RAM sequencer: money/key reads and checked coin transfers
// against a synchronous RAM with configurable read latency.
module ledger_access_sequencer #(
    parameter int NUM_PLAYERS = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int RD_LATENCY  = 2,
    localparam int PW         = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int ADDR_WIDTH = PW + 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [2:0]            process,
    input  logic [PW-1:0]         player_a,
    input  logic [PW-1:0]         player_b,
    input  logic [DATA_WIDTH-1:0] amount,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] result,
    output logic [2:0]            protocol,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [2:0]  OP_MONEY    = 3'b001;
    localparam logic [2:0]  OP_KEY      = 3'b010;
    localparam logic [2:0]  OP_XFER     = 3'b100;
    localparam logic [1:0]  FIELD_KEY   = 2'b01;
    localparam logic [1:0]  FIELD_MONEY = 2'b10;
    localparam logic [2:0]  LAT         = 3'(RD_LATENCY);
    localparam logic [PW:0] NP_LIMIT    = (PW+1)'(NUM_PLAYERS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CHECK = 3'd3,
        WR_A  = 3'd4,
        WR_B  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t                state;
    logic [2:0]            cnt;
    logic [PW-1:0]         pa_reg;
    logic [PW-1:0]         pb_reg;
    logic [DATA_WIDTH-1:0] amt_reg;
    logic [DATA_WIDTH-1:0] bal_a;
    logic [DATA_WIDTH-1:0] bal_b;

    logic                  op_read;
    logic                  op_xfer;
    logic                  a_ok;
    logic                  b_ok;
    logic                  req_ok;
    logic [DATA_WIDTH-1:0] diff_a;
    logic [DATA_WIDTH:0]   sum_b;

    assign op_read = (process == OP_MONEY) || (process == OP_KEY);
    assign op_xfer = (process == OP_XFER);
    assign a_ok    = {1'b0, player_a} < NP_LIMIT;
    assign b_ok    = {1'b0, player_b} < NP_LIMIT;
    assign req_ok  = a_ok && (op_read || (op_xfer && b_ok && (player_a != player_b)));

    // Extra carry bit on the credit side flags overflow of the destination balance.
    assign diff_a  = bal_a - amt_reg;
    assign sum_b   = {1'b0, bal_b} + {1'b0, amt_reg};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            pa_reg      <= '0;
            pb_reg      <= '0;
            amt_reg     <= '0;
            bal_a       <= '0;
            bal_b       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
            protocol    <= '0;
            mem_address <= '0;
            mem_wren    <= 1'b0;
            mem_data    <= '0;
        end else begin
            done     <= 1'b0;
            mem_wren <= 1'b0;
            mem_data <= '0;
            case (state)
                IDLE: begin
                    mem_address <= '0;
                    if (start) begin
                        pa_reg   <= player_a;
                        pb_reg   <= player_b;
                        amt_reg  <= amount;
                        protocol <= process;
                        busy     <= 1'b1;
                        result   <= '0;
                        cnt      <= '0;
                        if (!req_ok) begin
                            state <= DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state       <= RD_A;
                            error       <= 1'b0;
                            mem_address <= {player_a, (process == OP_KEY) ? FIELD_KEY : FIELD_MONEY};
                        end
                    end
                end
                RD_A: begin
                    if (cnt == LAT) begin
                        cnt <= '0;
                        if (protocol == OP_XFER) begin
                            bal_a       <= mem_q;
                            state       <= RD_B;
                            mem_address <= {pb_reg, FIELD_MONEY};
                        end else begin
                            result      <= mem_q;
                            state       <= DONE;
                            done        <= 1'b1;
                            mem_address <= '0;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RD_B: begin
                    if (cnt == LAT) begin
                        cnt         <= '0;
                        bal_b       <= mem_q;
                        state       <= CHECK;
                        mem_address <= '0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                CHECK: begin
                    // Both limits are checked before any write so a rejection leaves RAM intact.
                    if ((bal_a < amt_reg) || sum_b[DATA_WIDTH]) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        error  <= 1'b1;
                        result <= '0;
                    end else begin
                        state       <= WR_A;
                        mem_wren    <= 1'b1;
                        mem_address <= {pa_reg, FIELD_MONEY};
                        mem_data    <= diff_a;
                    end
                end
                WR_A: begin
                    state       <= WR_B;
                    mem_wren    <= 1'b1;
                    mem_address <= {pb_reg, FIELD_MONEY};
                    mem_data    <= sum_b[DATA_WIDTH-1:0];
                end
                WR_B: begin
                    state       <= DONE;
                    done        <= 1'b1;
                    result      <= diff_a;
                    mem_address <= '0;
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    protocol    <= '0;
                    mem_address <= '0;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    protocol    <= '0;
                    mem_address <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ledger_access_sequencer.sv
// Randomised scoreboard bench for ledger_access_sequencer with a latency-accurate RAM
// model and a ledger reference kept as plain per-player balances.
module tb_ledger_access_sequencer;

    localparam int NP = 3;
    localparam int DW = 8;
    localparam int L  = 2;
    localparam int PW = 2;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    process = '0;
    logic [PW-1:0] player_a = '0;
    logic [PW-1:0] player_b = '0;
    logic [DW-1:0] amount = '0;
    logic          busy, done, error, mem_wren;
    logic [DW-1:0] result, mem_data, mem_q;
    logic [2:0]    protocol;
    logic [AW-1:0] mem_address;

    ledger_access_sequencer #(.NUM_PLAYERS(NP), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
        .clock(clock), .resetn(resetn), .start(start), .process(process),
        .player_a(player_a), .player_b(player_b), .amount(amount),
        .busy(busy), .done(done), .error(error), .result(result), .protocol(protocol),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM: mem_q reflects the address presented L cycles earlier.
    logic [DW-1:0] ram [16];
    logic [DW-1:0] pipe [L];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    always @(posedge clock) begin
        if (bd_en) ram[bd_addr] <= bd_data;
        else if (mem_wren) ram[mem_address] <= mem_data;
        pipe[0] <= ram[mem_address];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_q = pipe[L-1];

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        logic [2:0]    proto;
        int            at;
    } exp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   ref_bal [NP];
    int   ref_key [NP];
    int   timeouts = 0;
    bit   finished = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    int   tests = 0;
    int   fails = 0;
    int   timeouts_seen = 0;
    bit   after_done = 1'b0;
    bit   final_done = 1'b0;

    always @(negedge clock) begin
        if (!resetn) begin
            tests++;
            if ({busy, done, error, mem_wren, result, protocol, mem_address, mem_data} != 0) begin
                fails++;
                $display("FAIL reset_outputs busy=%b done=%b error=%b wren=%b result=%h protocol=%b addr=%h data=%h required all zero",
                         busy, done, error, mem_wren, result, protocol, mem_address, mem_data);
            end
            after_done = 1'b0;
        end else begin
            if (after_done) begin
                tests++;
                if ({busy, done, protocol, mem_wren, mem_address} != 0) begin
                    fails++;
                    $display("FAIL idle_after_done busy=%b done=%b protocol=%b wren=%b addr=%h required all zero",
                             busy, done, protocol, mem_wren, mem_address);
                end
            end
            after_done = done;
            if (done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done cycle=%0d result=%h error=%b required no completion", cyc, result, error);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({result, error, protocol, busy} != {e.res, e.err, e.proto, 1'b1}) begin
                        fails++;
                        $display("FAIL done_outputs result=%h error=%b protocol=%b busy=%b required result=%h error=%b protocol=%b busy=1",
                                 result, error, protocol, busy, e.res, e.err, e.proto);
                    end
                    tests++;
                    if (cyc != e.at) begin
                        fails++;
                        $display("FAIL done_cycle got=%0d required=%0d", cyc, e.at);
                    end
                end
            end
            if (mem_wren) begin
                tests++;
                if (wr_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write addr=%h data=%h required no write", mem_address, mem_data);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    if ({mem_address, mem_data} != {w.addr, w.data}) begin
                        fails++;
                        $display("FAIL write addr=%h data=%h required addr=%h data=%h", mem_address, mem_data, w.addr, w.data);
                    end
                end
            end
        end
        if (timeouts != timeouts_seen) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout count=%0d required=0", timeouts);
            timeouts_seen = timeouts;
        end
        if (finished && !final_done) begin
            final_done = 1'b1;
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL pending_done left=%0d required=0", exp_q.size());
            end
            tests++;
            if (wr_q.size() != 0) begin
                fails++;
                $display("FAIL pending_write left=%0d required=0", wr_q.size());
            end
            for (int p = 0; p < NP; p++) begin
                tests++;
                if (ram[AW'(p*4+2)] != DW'(ref_bal[p])) begin
                    fails++;
                    $display("FAIL ledger_p%0d got=%0d required=%0d", p, ram[AW'(p*4+2)], ref_bal[p]);
                end
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // ---------------- driver ----------------
    task automatic bd_write(input int addr, input int data);
        bd_en   = 1'b1;
        bd_addr = AW'(addr);
        bd_data = DW'(data);
        @(posedge clock);
        #1 bd_en = 1'b0;
        @(negedge clock);
    endtask

    task automatic set_bal(input int p, input int v);
        bd_write(p*4+2, v);
        ref_bal[p] = v;
    endtask

    task automatic set_key(input int p, input int v);
        bd_write(p*4+1, v);
        ref_key[p] = v;
    endtask

    task automatic recover();
        resetn = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b1;
        exp_q.delete();
        wr_q.delete();
        @(negedge clock);
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge of the first idle cycle.
    task automatic run_op(input logic [2:0] op, input int a, input int b, input int amt, input bit poke);
        exp_t e;
        int   n;
        e.proto = op;
        e.err   = 1'b0;
        e.res   = '0;
        if (!(op == 3'b001 || op == 3'b010 || op == 3'b100) || a >= NP || (op == 3'b100 && (b >= NP || a == b))) begin
            e.err = 1'b1;
            e.at  = 1;
        end else if (op == 3'b001) begin
            e.res = DW'(ref_bal[a]);
            e.at  = L + 2;
        end else if (op == 3'b010) begin
            e.res = DW'(ref_key[a]);
            e.at  = L + 2;
        end else if (ref_bal[a] < amt || ref_bal[b] + amt > 255) begin
            e.err = 1'b1;
            e.at  = 2*L + 4;
        end else begin
            ref_bal[a] = ref_bal[a] - amt;
            ref_bal[b] = ref_bal[b] + amt;
            wr_q.push_back('{AW'(a*4+2), DW'(ref_bal[a])});
            wr_q.push_back('{AW'(b*4+2), DW'(ref_bal[b])});
            e.res = DW'(ref_bal[a]);
            e.at  = 2*L + 6;
        end
        e.at = e.at + cyc;
        exp_q.push_back(e);
        process  = op;
        player_a = PW'(a);
        player_b = PW'(b);
        amount   = DW'(amt);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        process  = 3'($urandom);
        player_a = PW'($urandom);
        player_b = PW'($urandom);
        amount   = DW'($urandom);
        n = 0;
        do begin
            @(negedge clock);
            n++;
            start = poke && (n == 1) && !done;
        end while (!done && n < 300);
        start = 1'b0;
        if (!done) begin
            timeouts++;
            recover();
        end else begin
            @(negedge clock);
        end
    endtask

    // Reset lands in WR_B, after the debit has been written but before the credit.
    task automatic reset_mid_transfer(input int a, input int b, input int amt);
        int n;
        ref_bal[a] = ref_bal[a] - amt;
        wr_q.push_back('{AW'(a*4+2), DW'(ref_bal[a])});
        process  = 3'b100;
        player_a = PW'(a);
        player_b = PW'(b);
        amount   = DW'(amt);
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_wren && n < 100);
        if (!mem_wren) begin
            timeouts++;
            recover();
        end else begin
            @(posedge clock);
            #1 resetn = 1'b0;
            @(negedge clock);
            @(negedge clock);
            #2 resetn = 1'b1;
            @(negedge clock);
        end
    endtask

    logic [2:0] bad_ops [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        int r, a, b, amt;
        logic [2:0] op;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 16; i++) bd_write(i, int'($urandom_range(0, 255)));
        for (int p = 0; p < NP; p++) begin
            set_bal(p, int'($urandom_range(0, 200)));
            set_key(p, int'($urandom_range(0, 255)));
        end

        // Directed cases
        set_bal(0, 50);
        set_bal(1, 20);
        set_key(1, 8'hA5);
        run_op(3'b001, 0, 0, 0, 1'b0);
        run_op(3'b010, 1, 0, 0, 1'b1);
        run_op(3'b100, 0, 1, 30, 1'b0);
        set_bal(0, 50);
        set_bal(1, 20);
        run_op(3'b100, 0, 1, 60, 1'b0);
        set_bal(1, 250);
        run_op(3'b100, 0, 1, 10, 1'b0);
        run_op(3'b011, 0, 1, 5, 1'b0);
        run_op(3'b100, 1, 1, 5, 1'b0);
        run_op(3'b001, 3, 0, 0, 1'b0);
        run_op(3'b100, 0, 3, 5, 1'b0);
        run_op(3'b100, 2, 0, 0, 1'b1);
        set_bal(0, 100);
        set_bal(1, 20);
        reset_mid_transfer(0, 1, 40);
        run_op(3'b001, 0, 0, 0, 1'b0);
        run_op(3'b001, 1, 0, 0, 1'b0);

        // Randomised traffic
        for (int t = 0; t < 60; t++) begin
            r   = int'($urandom_range(0, 9));
            a   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, NP-1));
            b   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, NP-1));
            amt = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 120));
            if (r <= 2)      op = 3'b001;
            else if (r <= 4) op = 3'b010;
            else if (r <= 8) op = 3'b100;
            else             op = bad_ops[$urandom_range(0, 4)];
            if (t % 10 == 9) set_bal(int'($urandom_range(0, NP-1)), int'($urandom_range(180, 255)));
            run_op(op, a, b, amt, (t % 4) == 0);
        end
        finished = 1'b1;
        repeat (5) @(negedge clock);
    end

endmodule
